// File: rtl/bits_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bits_pkg
// Description : Shared state encoding and helpers for the bit-sequence blocks
//               (transmitter and detector FSMs share the 2-bit state width).
// Revision    : 1.0 - initial release
// ============================================================================
package bits_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Width of a down-counter that must hold values 0..n-1 (at least 1 bit).
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/piso_shift.sv
`default_nettype none
// ============================================================================
// Module      : piso_shift
// Description : Parallel-load, MSB-first shift register. The active pattern is
//               left-aligned on load so bit [len-1] appears on dout first; zeros
//               fill from the bottom, so dout reads 0 once the frame has drained.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_shift #(
    parameter int WIDTH = 8,
    parameter int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    input  logic [LEN_W-1:0] len,
    output logic             dout
);

    localparam logic [LEN_W-1:0] c_WIDTH_L = LEN_W'(WIDTH);

    logic [WIDTH-1:0] r_sr;

    // Load left-aligned pattern, or shift one place toward the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr <= '0;
        end else if (load) begin
            r_sr <= din << (c_WIDTH_L - len);
        end else if (shift) begin
            r_sr <= {r_sr[WIDTH-2:0], 1'b0};
        end
    end

    assign dout = r_sr[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/bit_seq_gen.sv
`default_nettype none
// ============================================================================
// Module      : bit_seq_gen
// Description : Serial bit-pattern transmitter. Captures a pattern, shifts it
//               out MSB-first, repeats it N times (or until stop when N=0), with
//               an optional idle gap between frames. All outputs are flops.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_seq_gen
    import bits_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4,
    parameter int GAP   = 0,
    parameter int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic             stop,
    output logic             out,
    output logic             out_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

    localparam logic [LEN_W-1:0] c_WIDTH_L  = LEN_W'(WIDTH);
    localparam int               c_GAP_W    = cnt_width(GAP);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'((GAP > 0) ? GAP - 1 : 0);
    localparam bit               c_HAS_GAP  = (GAP > 0);

    state_t             r_state;
    logic [LEN_W-1:0]   r_bitcnt;   // bits still to send after the current one
    logic [CNT_W-1:0]   r_frmcnt;   // frames left including current; 0 = endless
    logic [c_GAP_W-1:0] r_gapcnt;
    logic               r_stop;
    logic [WIDTH-1:0]   r_pat;
    logic [LEN_W-1:0]   r_len;
    logic               r_out_valid;
    logic               r_frame_start;
    logic               r_busy;
    logic               r_done;

    state_t             w_state_nxt;
    logic               w_load;
    logic               w_shift;
    logic               w_capture;
    logic [WIDTH-1:0]   w_din;
    logic [LEN_W-1:0]   w_len_ld;
    logic [LEN_W-1:0]   w_bitcnt_nxt;
    logic [CNT_W-1:0]   w_frmcnt_nxt;
    logic [c_GAP_W-1:0] w_gapcnt_nxt;
    logic               w_len_ok;
    logic               w_stop_seen;
    logic               w_stop_nxt;

    // stop only counts while a run is active; it is forgotten on return to IDLE.
    assign w_len_ok    = (len != '0) && (len <= c_WIDTH_L);
    assign w_stop_seen = r_stop | (stop & (r_state != ST_IDLE));
    assign w_stop_nxt  = w_stop_seen & (w_state_nxt != ST_IDLE);

    // Next-state, counter and shift-register control decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_capture    = 1'b0;
        w_din        = r_pat;
        w_len_ld     = r_len;
        w_bitcnt_nxt = r_bitcnt;
        w_frmcnt_nxt = r_frmcnt;
        w_gapcnt_nxt = r_gapcnt;
        case (r_state)
            ST_IDLE: begin
                if (start && w_len_ok) begin
                    w_capture    = 1'b1;
                    w_load       = 1'b1;
                    w_din        = pattern;
                    w_len_ld     = len;
                    w_bitcnt_nxt = len - 1'b1;
                    w_frmcnt_nxt = repeat_n;
                    w_state_nxt  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_bitcnt != '0) begin
                    w_shift      = 1'b1;
                    w_bitcnt_nxt = r_bitcnt - 1'b1;
                end else begin
                    // Frame boundary: the count never moves in endless mode.
                    if (r_frmcnt != '0) begin
                        w_frmcnt_nxt = r_frmcnt - 1'b1;
                    end
                    if (!w_stop_seen && (r_frmcnt != CNT_W'(1))) begin
                        if (c_HAS_GAP) begin
                            w_shift      = 1'b1;
                            w_gapcnt_nxt = c_GAP_LAST;
                            w_state_nxt  = ST_GAP;
                        end else begin
                            w_load       = 1'b1;
                            w_bitcnt_nxt = r_len - 1'b1;
                        end
                    end else begin
                        // Drain the last bit so out returns to 0.
                        w_shift     = 1'b1;
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_GAP: begin
                if (r_gapcnt != '0) begin
                    w_gapcnt_nxt = r_gapcnt - 1'b1;
                end else if (w_stop_seen) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_load       = 1'b1;
                    w_bitcnt_nxt = r_len - 1'b1;
                    w_state_nxt  = ST_SHIFT;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counters, captured request and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_bitcnt      <= '0;
            r_frmcnt      <= '0;
            r_gapcnt      <= '0;
            r_stop        <= 1'b0;
            r_pat         <= '0;
            r_len         <= '0;
            r_out_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_bitcnt      <= w_bitcnt_nxt;
            r_frmcnt      <= w_frmcnt_nxt;
            r_gapcnt      <= w_gapcnt_nxt;
            r_stop        <= w_stop_nxt;
            if (w_capture) begin
                r_pat <= pattern;
                r_len <= len;
            end
            r_out_valid   <= (w_state_nxt == ST_SHIFT);
            r_frame_start <= w_load;
            r_busy        <= (w_state_nxt != ST_IDLE);
            r_done        <= (w_state_nxt == ST_DONE);
        end
    end

    piso_shift #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (w_load),
        .shift (w_shift),
        .din   (w_din),
        .len   (w_len_ld),
        .dout  (out)
    );

    assign out_valid   = r_out_valid;
    assign frame_start = r_frame_start;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bit_seq_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_seq_gen
// Description : Directed self-checking bench for bit_seq_gen (GAP=0 and GAP=2
//               instances). Observed word per cycle is
//               {out, out_valid, frame_start, busy, done}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_seq_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] repeat_n;

    logic out0, ov0, fs0, b0, d0;
    logic out2, ov2, fs2, b2, d2;
    logic [4:0] w_obs0;
    logic [4:0] w_obs2;

    int n_vec = 0;
    int n_err = 0;

    // "10" detector fed from the GAP=0 instance (loopback)
    logic r_dprev;
    logic r_dz;

    always #5 clk = ~clk;

    assign w_obs0 = {out0, ov0, fs0, b0, d0};
    assign w_obs2 = {out2, ov2, fs2, b2, d2};

    bit_seq_gen #(.WIDTH(8), .CNT_W(4), .GAP(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len),
        .repeat_n(repeat_n), .stop(stop), .out(out0), .out_valid(ov0),
        .frame_start(fs0), .busy(b0), .done(d0)
    );

    bit_seq_gen #(.WIDTH(8), .CNT_W(4), .GAP(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len),
        .repeat_n(repeat_n), .stop(stop), .out(out2), .out_valid(ov2),
        .frame_start(fs2), .busy(b2), .done(d2)
    );

    // Registered "10" detector: z high the cycle after a valid 0 preceded by a valid 1.
    always @(posedge clk) begin
        if (rst) begin
            r_dprev <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            r_dz <= ov0 && !out0 && r_dprev;
            if (ov0) r_dprev <= out0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        pattern  = '0;
        len      = '0;
        repeat_n = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Present a request for one edge; returns in the first cycle after that edge.
    task automatic go(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
        pattern  = p;
        len      = l;
        repeat_n = r;
        start    = 1'b1;
        tick();
        start = 1'b0;
    endtask

    logic [4:0] e1 [8]  = '{5'b11110, 5'b01010, 5'b11110, 5'b01010,
                            5'b11110, 5'b01010, 5'b00011, 5'b00000};
    logic [4:0] e3 [10] = '{5'b11110, 5'b11010, 5'b01010, 5'b00010, 5'b00010,
                            5'b11110, 5'b11010, 5'b01010, 5'b00011, 5'b00000};
    logic [4:0] el [4]  = '{5'b11110, 5'b11110, 5'b00011, 5'b00000};

    initial begin
        int zc;

        // Reset state
        do_reset();
        chk("reset_g0", w_obs0, 5'b00000);
        chk("reset_g2", w_obs2, 5'b00000);

        // 1/2: "10" x3 back-to-back, with loopback detector
        zc = 0;
        go(8'b0000_0010, 4'd2, 4'd3);
        for (int i = 0; i < 8; i++) begin
            if (r_dz) zc++;
            chk($sformatf("t1_c%0d", i + 1), w_obs0, e1[i]);
            tick();
        end
        chk("t2_det_z_count", zc, 3);

        // 3: GAP=2, "110" x2
        do_reset();
        go(8'b0000_0110, 4'd3, 4'd2);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t3_c%0d", i + 1), w_obs2, e3[i]);
            tick();
        end

        // 4: continuous "10", stop on the 5th bit
        do_reset();
        go(8'b0000_0010, 4'd2, 4'd0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t4_c%0d", i + 1), w_obs0, e1[i]);
            stop = (i == 4);
            tick();
        end
        stop = 1'b0;

        // 5: reset during 2nd bit, then fresh start right after release
        do_reset();
        go(8'b0000_0010, 4'd2, 4'd3);
        chk("t5_c1", w_obs0, 5'b11110);
        tick();
        chk("t5_c2", w_obs0, 5'b01010);
        rst = 1'b1;
        tick();
        chk("t5_rst_g0", w_obs0, 5'b00000);
        chk("t5_rst_g2", w_obs2, 5'b00000);
        rst   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t5_re_c%0d", i + 1), w_obs0, e1[i]);
            tick();
        end

        // 6a: invalid lengths ignored
        do_reset();
        pattern  = 8'hAA;
        len      = 4'd0;
        repeat_n = 4'd1;
        start    = 1'b1;
        tick();
        chk("t6_len0", w_obs0, 5'b00000);
        len = 4'd9;
        tick();
        chk("t6_len9", w_obs0, 5'b00000);
        start = 1'b0;
        tick();
        chk("t6_idle", w_obs0, 5'b00000);

        // 6b: start/input changes while busy and start during DONE ignored
        go(8'b0000_0010, 4'd2, 4'd3);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t6_c%0d", i + 1), w_obs0, e1[i]);
            if (i == 2) begin
                start = 1'b1; pattern = 8'hFF; len = 4'd8; repeat_n = 4'd1;
            end else begin
                start = (i == 6);
                pattern = 8'b0000_0010; len = 4'd2; repeat_n = 4'd3;
            end
            tick();
        end
        start = 1'b0;
        chk("t6_after", w_obs0, 5'b00000);

        // len=1 boundary: every bit starts a frame
        do_reset();
        go(8'b0000_0001, 4'd1, 4'd2);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("tl_c%0d", i + 1), w_obs0, el[i]);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
